// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game: state bus encoding
// used by the sequencer, the score datapath and the display.
package whack_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'b000,
        ST_WAIT  = 3'b001,
        ST_MOLE0 = 3'b010,
        ST_MOLE1 = 3'b011,
        ST_MOLE2 = 3'b100,
        ST_MOLE3 = 3'b101,
        ST_OVER  = 3'b110,
        ST_BAD   = 3'b111
    } state_t;

    // Bump to the next hole when the random pick repeats the last one.
    function automatic logic [1:0] pick_mole(
        input logic [1:0] raw,
        input logic [1:0] prev
    );
        return (raw == prev) ? raw + 2'd1 : raw;
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s != ST_IDLE) && (s != ST_OVER) && (s != ST_BAD);
    endfunction

endpackage

// File: rtl/whack_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), free running every cycle.
// Ports: clk, Reset (async, active-high), q = current register value.
module whack_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       Reset,
    output logic [7:0] q
);

    logic fb;

    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) q <= SEED;
        else       q <= {q[6:0], fb};
    end

endmodule

// File: rtl/whack_game_control.sv
// Whack-a-mole sequencer: state bus, mole pick, round count, high score.
// Ports: clk, Reset, start, enable_control, score[7:0] in;
//        state[2:0], round_count[7:0], high_score[7:0], new_record, busy out.
module whack_game_control
    import whack_pkg::*;
#(
    parameter int         NUM_ROUNDS = 16,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               start,
    input  logic               enable_control,
    input  logic [7:0]         score,
    output logic [STATE_W-1:0] state,
    output logic [7:0]         round_count,
    output logic [7:0]         high_score,
    output logic               new_record,
    output logic               busy
);

    localparam logic [7:0] LAST = 8'(NUM_ROUNDS);

    state_t     state_q, state_d;
    logic [7:0] rc_d, hs_d;
    logic       nr_d;
    logic [1:0] prev_mole, prev_d;
    logic [1:0] mole_n;
    logic       start_q, start_rise;
    logic [7:0] lfsr_q;
    logic       lfsr_unused;

    whack_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .Reset (Reset),
        .q     (lfsr_q)
    );

    // Only the two low bits choose a hole.
    assign lfsr_unused = ^lfsr_q[7:2];
    assign mole_n      = pick_mole(lfsr_q[1:0], prev_mole);
    assign start_rise  = start & ~start_q;
    assign state       = state_q;

    always_comb begin
        state_d = state_q;
        rc_d    = round_count;
        hs_d    = high_score;
        nr_d    = 1'b0;
        prev_d  = prev_mole;
        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (enable_control) begin
                    state_d = state_t'(3'd2 + {1'b0, mole_n});
                    prev_d  = mole_n;
                    rc_d    = round_count + 8'd1;
                end
            end
            ST_MOLE0, ST_MOLE1, ST_MOLE2, ST_MOLE3: begin
                if (enable_control) begin
                    if (round_count == LAST) begin
                        state_d = ST_OVER;
                        if (score > high_score) begin
                            hs_d = score;
                            nr_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A game never carries its round count into IDLE.
        if (state_d == ST_IDLE) rc_d = '0;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            round_count <= '0;
            high_score  <= '0;
            new_record  <= 1'b0;
            busy        <= 1'b0;
            prev_mole   <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_count <= rc_d;
            high_score  <= hs_d;
            new_record  <= nr_d;
            busy        <= is_busy(state_d);
            prev_mole   <= prev_d;
            start_q     <= start;
        end
    end

endmodule
